// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N-way select (mux_n_pipe)
// and its generic 2-entry skid buffer.
package mux_pkg;

    // Largest supported number of selectable inputs.
    localparam int MUX_MAX_INPUTS = 16;

    // Buffer occupancy, encoded as {skid_valid, main_valid}; 2'b10 never occurs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_t;

    // Width of an encoded select for n inputs (at least 1 bit).
    function automatic int sel_bits(input int n);
        int w;
        w = 1;
        while (((1 << w) < n) && (w < $clog2(MUX_MAX_INPUTS)))
            w++;
        return w;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer: 1-cycle latency, full
// throughput, and an input ready that depends only on registered state.
module skid_buf
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // Ready drops while reset is held; otherwise only a full skid blocks input.
    assign o_ready  = ~r_state[1] & ~i_rst;
    assign o_valid  = r_state[0];
    assign o_data   = r_main;
    assign w_accept = i_valid & o_ready;
    assign w_drain  = o_valid & i_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic from the accept/drain handshakes.
    // NOTE: the default assignment at the top keeps this combinational block latch-free.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_nxt = ONE;
            ONE: begin
                if (w_accept && !w_drain)
                    w_state_nxt = FULL;
                else if (!w_accept && w_drain)
                    w_state_nxt = EMPTY;
            end
            FULL:    if (w_drain) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Load enables for the main and skid registers.
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: w_load_main_in = w_accept;
            ONE: begin
                w_load_main_in = w_accept & w_drain;
                w_load_skid    = w_accept & ~w_drain;
            end
            FULL:    w_load_main_skid = w_drain;
            default: ;
        endcase
    end

    // Data registers; the skid word moves to main before any new word can enter.
    // NOTE: the data registers are reset so the output word reads zero after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in)
                r_main <= i_data;
            else if (w_load_main_skid)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= i_data;
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N-way word select: picks in_data[control] (word 0 when control
// is out of range), registers it with its select behind a skid buffer.
// Optional feature macro: MUX_N_PIPE_SEL_ERR_EN adds a sticky sel_err flag
// for out-of-range selects, cleared by sel_err_clr.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int NUM_BITS   = 32,
    parameter  int NUM_INPUTS = 4,
    localparam int SEL_BITS   = sel_bits(NUM_INPUTS)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_INPUTS*NUM_BITS-1:0] in_data,
    input  logic [SEL_BITS-1:0]            control,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_BITS-1:0]            out,
    output logic [SEL_BITS-1:0]            out_sel,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef MUX_N_PIPE_SEL_ERR_EN
    ,
    input  logic                           sel_err_clr,
    output logic                           sel_err
`endif
);

    localparam int PIPE_W = NUM_BITS + SEL_BITS;

    logic [NUM_BITS-1:0] w_word;
    logic [PIPE_W-1:0]   w_pipe_out;

    // Word select; anything not matching a real input falls back to word 0.
    always_comb begin
        w_word = in_data[NUM_BITS-1:0];
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (control == SEL_BITS'(i))
                w_word = in_data[i*NUM_BITS +: NUM_BITS];
        end
    end

    // The select travels with its word so out_sel always matches out.
    skid_buf #(
        .WIDTH (PIPE_W)
    ) u_skid_buf (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_data  ({control, w_word}),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (w_pipe_out),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign out     = w_pipe_out[NUM_BITS-1:0];
    assign out_sel = w_pipe_out[PIPE_W-1:NUM_BITS];

`ifdef MUX_N_PIPE_SEL_ERR_EN
    logic w_accept;
    logic w_in_range;
    logic r_sel_err;

    assign w_accept   = in_valid & in_ready;
    assign w_in_range = (int'(control) < NUM_INPUTS);
    assign sel_err    = r_sel_err;

    // Sticky error flag; a new out-of-range accept wins over a clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_sel_err <= 1'b0;
        else if (w_accept && !w_in_range)
            r_sel_err <= 1'b1;
        else if (sel_err_clr)
            r_sel_err <= 1'b0;
    end
`endif

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised successor of the 3-way bus mux.
- Selects one of NUM_INPUTS words of NUM_BITS using an encoded select.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput and 1-cycle latency.
- Used where a writeback/forwarding select must be cut from a long combinational path, e.g. the WB-stage BusW select in each core.

Parameters:
- NUM_BITS, 32, width of each data input and of the output.
- NUM_INPUTS, 4, number of selectable inputs; legal range 2..16.
- SEL_BITS, $clog2(NUM_INPUTS), width of control; derived, not overridden.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- in_data  input  NUM_INPUTS*NUM_BITS  packed inputs; word i at bits [i*NUM_BITS +: NUM_BITS].
- control  input  SEL_BITS  encoded select, sampled with in_data.
- in_valid  input  1  upstream word/select valid.
- in_ready  output  1  block can accept this cycle.
- out  output  NUM_BITS  selected, registered word.
- out_sel  output  SEL_BITS  select value that produced out (echo for debug/forwarding).
- out_valid  output  1  out/out_sel valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Clocking and reset: one clock CLK; RST is asynchronous, active-high.
- Reset values: main and skid entries invalid; out=0, out_sel=0, out_valid=0.
  - in_ready=0 while RST is high, 1 in the first cycle after release.
- Select:
  - Word = in_data slice[control] when control < NUM_INPUTS.
  - Otherwise word 0 (the default-to-in_0 rule), out_sel = control unchanged.
- Transfers:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Storage: main register (drives out*) and skid register, each with a valid bit.
- Outputs: in_ready = ~skid_valid (registered-only, no combinational path from out_ready). out_valid = main_valid.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY(00):
    - accept -> main loads, go ONE.
  - ONE(01):
    - accept & drain -> main reloads, stay ONE.
    - accept & ~drain -> skid loads, go FULL.
    - ~accept & drain -> go EMPTY.
  - FULL(11):
    - no accept is possible.
    - drain -> main <= skid, skid invalid, go ONE.
  - State 10 is unreachable.
- Latency: a word accepted at edge N appears on out after edge N (visible cycle N+1) when main was empty or draining. Throughput is one word/cycle with out_ready held high.
- Ordering: strictly FIFO; the skid word is never overtaken.
- Hold: out/out_sel stable while out_valid & ~out_ready.
- Reset mid-operation: both entries are discarded immediately; no partial output.
- in_data/control are ignored when not accepted.

Optional Feature:
- Macro: MUX_N_PIPE_SEL_ERR_EN.
- Defined:
  - Adds output sel_err (1 bit), plus input sel_err_clr (1 bit).
  - sel_err is sticky: set on any accept with control >= NUM_INPUTS.
  - Cleared by sel_err_clr or RST; set wins over a simultaneous clear.
- Undefined: ports absent; out-of-range select silently yields word 0.

Decomposition:
- Package mux_pkg:
  - MUX_MAX_INPUTS=16.
  - typedef enum logic [1:0] skid_state_t {EMPTY, ONE, FULL}.
  - Function sel_bits(n).
- Sub-module skid_buf (#(WIDTH)): generic 2-entry valid/ready buffer.
  - mux_n_pipe instantiates it with WIDTH = NUM_BITS+SEL_BITS.
  - Select logic stays in mux_n_pipe.

Test Plan:
- Reset/basic select:
  - RST high: out_valid=0, in_ready=0.
  - Release; NUM_INPUTS=4, in_data={D,C,B,A}=32'hDDDD_0003..32'hAAAA_0000; control=2, in_valid=1, out_ready=1.
  - Next cycle: out=C, out_sel=2, out_valid=1.
- Streaming: 8 words, control 0..3 repeating, out_ready=1 -> 8 outputs on consecutive cycles, in_ready never drops.
- Backpressure/skid:
  - out_ready=0 and send W1, W2.
  - Expect W1 held on out; in_ready=0 after W2 accepted.
  - Raise out_ready -> W1 then W2; in_ready returns to 1 the cycle after W1 drains.
- Out-of-range: NUM_INPUTS=3, control=3 -> out=in_0 word, out_sel=3; with MUX_N_PIPE_SEL_ERR_EN, sel_err=1 until sel_err_clr.
- Async reset mid-operation: FULL state, assert RST between edges -> out_valid=0 immediately; post-release first output is the next accepted word.
- Parameter sweep: NUM_INPUTS=2,5,16, NUM_BITS=1,32 -> random select/backpressure versus scoreboard; order preserved, no loss or duplication.
